bit_serializer: RTL and testbench



---
 rtl/bit_serializer.sv | 212 +++++++++++++++++++++
 tb/tb_bit_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Takes WIDTH-bit words over a valid/ready handshake, queues them in a
//   DEPTH-entry FIFO and plays them out one bit per cycle with a per-bit
//   valid strobe. The output side never stalls; optional idle gaps follow
//   each word.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   DEPTH      FIFO depth in words (power of two, >= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   GAP        idle cycles after each word (0..15)
//
// Build option
//   BIT_SERIALIZER_PARITY_EN  when defined, each word is followed by one
//                             extra valid cycle carrying its even parity.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active low
//   data_i        input word
//   data_valid_i  data_i is valid
//   data_ready_o  FIFO can accept a word (registered)
//   valid_o       d_o carries a serial bit this cycle (registered)
//   d_o           serial bit, 0 when valid_o is 0 (registered)
//   sow_o         first bit of a word (registered)
//   busy_o        FIFO not empty or FSM not idle
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             valid_o,
    output logic             d_o,
    output logic             sow_o,
    output logic             busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH-1);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP-1) : 4'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd2;
`endif
    localparam logic [1:0] S_GAP   = 2'd3;

    // FIFO
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_ready;

    // serializer
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bcnt;
    logic [3:0]       r_gcnt;
    logic             r_valid;
    logic             r_d;
    logic             r_sow;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             r_par;
`endif

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_word_done;
    logic [AW:0]      w_count_next;
    logic [WIDTH-1:0] w_rd_data;

    assign w_rd_data = r_mem[r_rptr];

    always_comb begin
        w_empty = (r_count == '0);
        w_push  = data_valid_i & r_ready;
        // Last cycle of a word's valid bits: its exit decides GAP / reload / IDLE.
`ifdef BIT_SERIALIZER_PARITY_EN
        w_word_done = (r_state == S_PAR);
`else
        w_word_done = (r_state == S_SHIFT) && (r_bcnt == '0);
`endif
        // Pop only on the edge where the FSM takes a new word into the shifter.
        w_pop = !w_empty && ((r_state == S_IDLE) ||
                             (w_word_done && (GAP == 0)) ||
                             ((r_state == S_GAP) && (r_gcnt == '0)));
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_ONE;
        else if (w_pop && !w_push)
            w_count_next = r_count - CNT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_next;
            // Registered from the next count so a fill to DEPTH drops ready on the same edge.
            r_ready <= (w_count_next != CNT_FULL);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_gcnt  <= '0;
            r_valid <= 1'b0;
            r_d     <= 1'b0;
            r_sow   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_d     <= 1'b0;
            r_sow   <= 1'b0;
            if (w_pop) begin
                // First bit goes straight to d_o; shifter keeps the rest.
                r_state <= S_SHIFT;
                r_bcnt  <= BIT_LAST;
                r_valid <= 1'b1;
                r_sow   <= 1'b1;
                if (MSB_FIRST != 0) begin
                    r_d     <= w_rd_data[WIDTH-1];
                    r_shift <= {w_rd_data[WIDTH-2:0], 1'b0};
                end else begin
                    r_d     <= w_rd_data[0];
                    r_shift <= {1'b0, w_rd_data[WIDTH-1:1]};
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                r_par   <= ^w_rd_data;
`endif
            end else if (w_word_done) begin
                if (GAP > 0) begin
                    r_state <= S_GAP;
                    r_gcnt  <= GAP_LOAD;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (r_bcnt != '0) begin
                            r_valid <= 1'b1;
                            r_bcnt  <= r_bcnt - BIT_ONE;
                            if (MSB_FIRST != 0) begin
                                r_d     <= r_shift[WIDTH-1];
                                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                            end else begin
                                r_d     <= r_shift[0];
                                r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                            end
                        end
`ifdef BIT_SERIALIZER_PARITY_EN
                        else begin
                            r_state <= S_PAR;
                            r_valid <= 1'b1;
                            r_d     <= r_par;
                        end
`endif
                    end
                    S_GAP: begin
                        if (r_gcnt != '0)
                            r_gcnt <= r_gcnt - 4'd1;
                        else
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data_ready_o = r_ready;
    assign valid_o      = r_valid;
    assign d_o          = r_d;
    assign sow_o        = r_sow;
    assign busy_o       = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (GAP=0/MSB first and GAP=3/LSB
// first) share stimulus. A word-level model assigns each accepted word a
// start cycle and derives every output from that schedule.
module tb_bit_serializer;

    localparam int W   = 8;
    localparam int DEP = 4;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PA  = W + P;
    localparam int MAXW = 2048;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic       data_valid_i;

    logic a_ready, a_valid, a_d, a_sow, a_busy;
    logic g_ready, g_valid, g_d, g_sow, g_busy;

    bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .GAP(0)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(a_ready), .valid_o(a_valid), .d_o(a_d), .sow_o(a_sow), .busy_o(a_busy));

    bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .GAP(3)) u_g (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(g_ready), .valid_o(g_valid), .d_o(g_d), .sow_o(g_sow), .busy_o(g_busy));

    always #5 clk_i = ~clk_i;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] wq [2][MAXW];
    int         aq [2][MAXW];
    int         sq [2][MAXW];
    int         nw [2];
    int         lo [2];
    int         cyc = 0;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int msb_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int m_cnt(input int k, input int c);
        int n = 0;
        for (int i = lo[k]; i < nw[k]; i++) begin
            if (aq[k][i] <= c) n++;
            if (sq[k][i] <= c) n--;
        end
        return n;
    endfunction

    function automatic bit m_ready(input int k, input int c);
        return (c >= 1) && (m_cnt(k, c) != DEP);
    endfunction

    task automatic m_push(input int k, input logic [7:0] d, input int e);
        int st;
        st = e + 1;
        if (nw[k] > 0 && sq[k][nw[k]-1] + PA + gap_of(k) > st)
            st = sq[k][nw[k]-1] + PA + gap_of(k);
        if (nw[k] >= MAXW) begin
            nerr++;
            $display("FAIL model_overflow: got %0d expected below %0d", nw[k], MAXW);
        end else begin
            wq[k][nw[k]] = d;
            aq[k][nw[k]] = e;
            sq[k][nw[k]] = st;
            nw[k]++;
        end
    endtask

    task automatic m_out(input int k, input int c,
                         output logic v, output logic d, output logic s,
                         output logic r, output logic b);
        int cnt, st, j;
        v = 1'b0; d = 1'b0; s = 1'b0;
        cnt = m_cnt(k, c);
        r = (c >= 1) && (cnt != DEP);
        b = (cnt != 0);
        for (int i = lo[k]; i < nw[k]; i++) begin
            st = sq[k][i];
            if (st <= c && c < st + PA + gap_of(k)) b = 1'b1;
            if (st <= c && c < st + PA) begin
                j = c - st;
                v = 1'b1;
                if (j < W) begin
                    d = wq[k][i][(msb_of(k) != 0) ? (W-1-j) : j];
                    s = (j == 0);
                end else begin
                    d = ^wq[k][i];
                end
            end
        end
    endtask

    initial begin
        nw[0] = 0; nw[1] = 0; lo[0] = 0; lo[1] = 0;
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) begin
                cyc = 0;
                nw[0] = 0; nw[1] = 0; lo[0] = 0; lo[1] = 0;
            end else begin
                for (int k = 0; k < 2; k++)
                    if (data_valid_i && m_ready(k, cyc))
                        m_push(k, data_i, cyc + 1);
                cyc++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic ev, ed, es, er, eb;
        forever begin
            @(negedge clk_i);
            for (int k = 0; k < 2; k++)
                while (lo[k] < nw[k] && sq[k][lo[k]] + PA + gap_of(k) <= cyc) lo[k]++;
            m_out(0, cyc, ev, ed, es, er, eb);
            chk("a_valid", a_valid, ev); chk("a_d", a_d, ed); chk("a_sow", a_sow, es);
            chk("a_ready", a_ready, er); chk("a_busy", a_busy, eb);
            m_out(1, cyc, ev, ed, es, er, eb);
            chk("g_valid", g_valid, ev); chk("g_d", g_d, ed); chk("g_sow", g_sow, es);
            chk("g_ready", g_ready, er); chk("g_busy", g_busy, eb);
        end
    end

    // ---------------- stimulus + literal checks ----------------
    initial begin
        logic [7:0]  pat;
        logic [23:0] p24;
        logic        ev, ed;
        int          seen;
        rst_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", a_ready, 0); chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);   chk("rst_d", a_d, 0); chk("rst_sow", a_sow, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", a_ready, 1);

        // single word 0xB2
        pat = 8'hB2; data_i = pat; data_valid_i = 1'b1;
        @(negedge clk_i);
        data_valid_i = 1'b0;
        chk("t1_not_yet", a_valid, 0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_i);
            chk("t1_valid", a_valid, 1);
            chk("t1_bit", a_d, pat[7-j]);
            chk("t1_sow", a_sow, (j == 0));
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        @(negedge clk_i);
        chk("t1_par_valid", a_valid, 1); chk("t1_par_bit", a_d, 0); chk("t1_par_sow", a_sow, 0);
`endif
        @(negedge clk_i);
        chk("t1_idle_valid", a_valid, 0); chk("t1_idle_busy", a_busy, 0);
        repeat (50) @(negedge clk_i);

`ifndef BIT_SERIALIZER_PARITY_EN
        // back-to-back 0xFF, 0x00, 0xA5
        p24 = 24'hFF00A5; data_i = 8'hFF; data_valid_i = 1'b1;
        for (int t = 0; t < 26; t++) begin
            @(negedge clk_i);
            if (t == 0) data_i = 8'h00;
            else if (t == 1) data_i = 8'hA5;
            else data_valid_i = 1'b0;
            if (t <= 24) chk("b2b_ready", a_ready, 1);
            if (t >= 1 && t <= 24) begin
                chk("b2b_valid", a_valid, 1);
                chk("b2b_bit", a_d, p24[24-t]);
            end
            if (t == 25) chk("b2b_end", a_valid, 0);
        end
        repeat (50) @(negedge clk_i);

        // GAP=3, LSB first: 0x01 then 0x80
        data_i = 8'h01; data_valid_i = 1'b1;
        for (int t = 0; t < 21; t++) begin
            @(negedge clk_i);
            if (t == 0) data_i = 8'h80;
            else data_valid_i = 1'b0;
            if (t >= 1) begin
                ev = (t <= 8) || (t >= 12 && t <= 19);
                ed = (t == 1) || (t == 19);
                chk("gap_valid", g_valid, ev);
                chk("gap_bit", g_d, ed);
            end
        end
        repeat (50) @(negedge clk_i);
`else
        // parity: 0x07 twice, 9-cycle period
        pat = 8'h07; data_i = pat; data_valid_i = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk_i);
            if (t >= 1) data_valid_i = 1'b0;
            if (t >= 1 && t <= 8) begin
                chk("par_valid", a_valid, 1); chk("par_bit", a_d, pat[8-t]);
            end
            if (t == 9) begin
                chk("par_pvalid", a_valid, 1); chk("par_pbit", a_d, 1); chk("par_psow", a_sow, 0);
            end
            if (t == 10) begin
                chk("par_next_valid", a_valid, 1); chk("par_next_sow", a_sow, 1);
            end
        end
        repeat (50) @(negedge clk_i);
`endif

        // FIFO full with serializer busy
        data_i = 8'h10; data_valid_i = 1'b1;
        for (int k = 0; k <= PA + 1; k++) begin
            @(negedge clk_i);
            data_i = data_i + 8'd1;
            if (k <= 3) chk("full_ready_hi", a_ready, 1);
            else if (k <= PA) chk("full_ready_lo", a_ready, 0);
            else begin
                chk("full_ready_back", a_ready, 1);
                data_valid_i = 1'b0;
            end
        end
        repeat (80) @(negedge clk_i);

        // reset during bit 4 of a word with two words queued
        data_i = 8'h3C; data_valid_i = 1'b1;
        @(negedge clk_i); data_i = 8'h5A;
        @(negedge clk_i); data_i = 8'hC3;
        @(negedge clk_i); data_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("mid_valid_before", a_valid, 1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_valid", a_valid, 0); chk("arst_d", a_d, 0); chk("arst_sow", a_sow, 0);
        chk("arst_busy", a_busy, 0);   chk("arst_ready", a_ready, 0);
        chk("arst_g_valid", g_valid, 0); chk("arst_g_busy", g_busy, 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (a_valid || g_valid || a_busy || g_busy) seen++;
        end
        chk("post_rst_quiet", seen, 0);

        // random traffic
        for (int i = 0; i < 5200; i++) begin
            @(negedge clk_i);
            data_valid_i = ($urandom_range(0, 99) < 70);
            data_i = 8'($urandom);
        end
        @(negedge clk_i);
        data_valid_i = 1'b0;
        repeat (200) @(negedge clk_i);
        chk("drain_a_idle", a_busy, 0);
        chk("drain_g_idle", g_busy, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
